count_pipe: RTL and testbench

//   Two-stage pipelined execution unit for the Zbb count ops: cpop, clz and ctz.

---
 rtl/count_pkg.sv | 37 +++
 rtl/PopCnt.sv | 15 +
 rtl/cnt_prep.sv | 27 ++
 rtl/count_pipe.sv | 128 ++++++++++++
 tb/tb_count_pipe.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared types and helpers for the Zbb count pipeline (cpop/clz/ctz, optional orc.b).
// Optional feature macro: COUNT_PIPE_ORCB_EN (enables op 3 = orc.b).
package count_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    CNT_CPOP = 2'd0,
    CNT_CLZ  = 2'd1,
    CNT_CTZ  = 2'd2,
    CNT_ORCB = 2'd3
  } cnt_op_t;

  // Propagate the highest set bit downwards so popcount equals XLEN - clz.
  function automatic logic [XLEN-1:0] smear(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] s;
    s = a;
    s = s | (s >> 1);
    s = s | (s >> 2);
    s = s | (s >> 4);
    s = s | (s >> 8);
    s = s | (s >> 16);
    return s;
  endfunction

`ifdef COUNT_PIPE_ORCB_EN
  // Each byte becomes FF when any of its bits is set, else 00.
  function automatic logic [XLEN-1:0] orcByte(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] r;
    for (int b = 0; b < XLEN / 8; b++) begin
      r[b*8 +: 8] = (a[b*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/PopCnt.sv
// Combinational population count of a 32-bit vector.
module PopCnt (
  input  logic [31:0] din,
  output logic [5:0]  cnt
);

  // Sum every bit of the input vector.
  always_comb begin
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, din[i]};
    end
  end

endmodule

// File: rtl/cnt_prep.sv
// Stage-1 operand transform: turns the operand into a popcount-ready vector
// (or the final orc.b word when COUNT_PIPE_ORCB_EN is defined).
module cnt_prep
  import count_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  output logic [31:0] vec
);

  // Select the transform matching the requested count op.
  always_comb begin
    vec = a;
    case (cnt_op_t'(op))
      CNT_CPOP: vec = a;
      CNT_CLZ:  vec = smear(a);
      CNT_CTZ:  vec = ~a & (a - 32'd1);
`ifdef COUNT_PIPE_ORCB_EN
      CNT_ORCB: vec = orcByte(a);
`else
      CNT_ORCB: vec = a;  // op 3 without orc.b support behaves as cpop
`endif
      default:  vec = a;
    endcase
  end

endmodule

// File: rtl/count_pipe.sv
// Two-stage pipelined Zbb count unit (cpop, clz, ctz) with valid/ready on both sides.
// Optional feature macro: COUNT_PIPE_ORCB_EN (op 3 = orc.b, bypasses the popcount).
module count_pipe
  import count_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1Valid_r;
  cnt_op_t          s1Op_r;
  logic [31:0]      s1Vec_r;
  logic [TAG_W-1:0] s1Tag_r;

  logic             s2Valid_r;
  logic [31:0]      s2Res_r;
  logic [TAG_W-1:0] s2Tag_r;

  logic        s2Adv_s;
  logic        s1Load_s;
  logic [31:0] prepVec_s;
  logic [5:0]  cnt_s;
  logic [31:0] resNext_s;

  // Stage 2 may take a new op when empty or when its result is consumed now.
  assign s2Adv_s   = ~s2Valid_r | out_ready;
  // Ready path is combinational from out_ready; no skid buffer.
  assign in_ready  = ~s1Valid_r | s2Adv_s;
  // An op offered during a flush is dropped.
  assign s1Load_s  = in_valid & in_ready & ~flush;

  assign out_valid = s2Valid_r;
  assign out_res   = s2Res_r;
  assign out_tag   = s2Tag_r;

  cnt_prep uPrep (
    .op  (in_op),
    .a   (in_a),
    .vec (prepVec_s)
  );

  PopCnt uPopCnt (
    .din (s1Vec_r),
    .cnt (cnt_s)
  );

  // Build the final result from the popcount of the stage-1 vector.
  always_comb begin
    resNext_s = {26'd0, cnt_s};
    case (s1Op_r)
      CNT_CPOP: resNext_s = {26'd0, cnt_s};
      CNT_CLZ:  resNext_s = {26'd0, 6'd32 - cnt_s};  // cnt <= 32, so no borrow
      CNT_CTZ:  resNext_s = {26'd0, cnt_s};
`ifdef COUNT_PIPE_ORCB_EN
      CNT_ORCB: resNext_s = s1Vec_r;                // orc.b word already formed in S1
`else
      CNT_ORCB: resNext_s = {26'd0, cnt_s};
`endif
      default:  resNext_s = {26'd0, cnt_s};
    endcase
  end

  // Stage-1 occupancy: cleared by flush, refilled whenever the stage can accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_r <= 1'b0;
    end else if (flush) begin
      s1Valid_r <= 1'b0;
    end else if (in_ready) begin
      s1Valid_r <= in_valid;
    end else begin
      s1Valid_r <= s1Valid_r;
    end
  end

  // Stage-1 payload: captured on accept, held otherwise; no reset needed.
  always_ff @(posedge clk) begin
    if (s1Load_s) begin
      s1Op_r  <= cnt_op_t'(in_op);
      s1Vec_r <= prepVec_s;
      s1Tag_r <= in_tag;
    end else begin
      s1Op_r  <= s1Op_r;
      s1Vec_r <= s1Vec_r;
      s1Tag_r <= s1Tag_r;
    end
  end

  // Stage-2 occupancy: cleared by flush, advances from stage 1 when allowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_r <= 1'b0;
    end else if (flush) begin
      s2Valid_r <= 1'b0;
    end else if (s2Adv_s) begin
      s2Valid_r <= s1Valid_r;
    end else begin
      s2Valid_r <= s2Valid_r;
    end
  end

  // Output result and tag: loaded on advance, held stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Res_r <= 32'd0;
      s2Tag_r <= '0;
    end else if (s2Adv_s & s1Valid_r & ~flush) begin
      s2Res_r <= resNext_s;
      s2Tag_r <= s1Tag_r;
    end else begin
      s2Res_r <= s2Res_r;
      s2Tag_r <= s2Tag_r;
    end
  end

endmodule

// File: tb/tb_count_pipe.sv
// Directed self-checking bench for count_pipe.
module tb_count_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = 32'd0;
  logic [5:0]  in_tag = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [5:0]  out_tag;

  int nChecks = 0;
  int nFails  = 0;

  count_pipe #(.TAG_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [5:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_tag   = tag;
  endtask

  // Single op with out_ready=1: not visible after first edge, visible after second.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [5:0] tag, input logic [31:0] expRes);
    offer(op, a, tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkEq({name, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkEq({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkEq({name, "_res"}, out_res, expRes);
    checkEq({name, "_tag"}, {26'd0, out_tag}, {26'd0, tag});
    @(posedge clk); #1;
  endtask

  logic sawValid;

  initial begin
    // Reset
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkEq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("rst_out_res", out_res, 32'd0);
    checkEq("rst_out_tag", {26'd0, out_tag}, 32'd0);
    checkEq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic function and boundaries
    runOp("cpop_f0f0", 2'd0, 32'hF0F0_0001, 6'd5,  32'd9);
    runOp("cpop_zero", 2'd0, 32'h0000_0000, 6'd6,  32'd0);
    runOp("cpop_ones", 2'd0, 32'hFFFF_FFFF, 6'd7,  32'd32);
    runOp("clz_8000",  2'd1, 32'h0000_8000, 6'd8,  32'd16);
    runOp("clz_zero",  2'd1, 32'h0000_0000, 6'd9,  32'd32);
    runOp("clz_ones",  2'd1, 32'hFFFF_FFFF, 6'd10, 32'd0);
    runOp("clz_msb",   2'd1, 32'h8000_0000, 6'd11, 32'd0);
    runOp("ctz_0100",  2'd2, 32'h0000_0100, 6'd12, 32'd8);
    runOp("ctz_zero",  2'd2, 32'h0000_0000, 6'd13, 32'd32);
    runOp("ctz_msb",   2'd2, 32'h8000_0000, 6'd14, 32'd31);
`ifdef COUNT_PIPE_ORCB_EN
    runOp("op3_orcb",  2'd3, 32'h0001_0300, 6'd15, 32'h00FF_FF00);
`else
    runOp("op3_cpop",  2'd3, 32'h0001_0300, 6'd15, 32'd3);
`endif

    // Back-to-back with a 3-cycle output stall
    out_ready = 1'b0;
    offer(2'd0, 32'h0000_00FF, 6'd20);
    #1 checkEq("stall_rdy0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    offer(2'd1, 32'h0000_0001, 6'd21);
    checkEq("stall_rdy1", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    offer(2'd2, 32'h0000_0010, 6'd22);
    checkEq("stall_rdy2", {31'd0, in_ready}, 32'd0);
    checkEq("stall_a_res", out_res, 32'd8);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkEq("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      checkEq("stall_hold_res", out_res, 32'd8);
      checkEq("stall_hold_tag", {26'd0, out_tag}, 32'd20);
      checkEq("stall_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 checkEq("stall_release_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkEq("order_b_res", out_res, 32'd31);
    checkEq("order_b_tag", {26'd0, out_tag}, 32'd21);
    @(posedge clk); #1;
    checkEq("order_c_valid", {31'd0, out_valid}, 32'd1);
    checkEq("order_c_res", out_res, 32'd4);
    checkEq("order_c_tag", {26'd0, out_tag}, 32'd22);
    @(posedge clk); #1;
    checkEq("order_drain", {31'd0, out_valid}, 32'd0);

    // Flush with both stages full and a third op offered
    out_ready = 1'b0;
    offer(2'd0, 32'h0000_000F, 6'd30);
    @(posedge clk); #1;
    offer(2'd0, 32'h0000_00FF, 6'd31);
    @(posedge clk); #1;
    checkEq("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    offer(2'd0, 32'h0000_0FFF, 6'd32);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checkEq("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkEq("flush_no_emit", {31'd0, sawValid}, 32'd0);

    // Pipe still usable after flush
    runOp("post_flush", 2'd2, 32'h0000_0040, 6'd33, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
